// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Keeps the PC and fetches over a req/ack instruction-memory handshake with one
// request outstanding. A one-entry skid buffer absorbs an ack that arrives while
// ID is stalled. The stage honours ID-resolved redirects with one branch delay slot.
// Optional macro IF_PERF_CNT_EN adds the stall-cycle and bubble counters.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] dinst_q, dinst_d;
  logic [XLEN-1:0] dpc4_q, dpc4_d;
  logic            dvalid_q, dvalid_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            ack_c;
  logic            redirect_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] target_c;

  assign ack_c      = imem_ack & req_q;
  assign redirect_c = dvalid_q & wpcir & (pcsource != 2'b00);
  assign pc_plus4_c = pc_q + XLEN'(4);

  // Redirect target selected by the ID-stage pcsource
  always_comb begin
    target_c = pc_plus4_c;
    case (pcsource)
      2'b01:   target_c = bpc;
      2'b10:   target_c = rpc;
      2'b11:   target_c = jpc;
      default: target_c = pc_plus4_c;
    endcase
  end

  // Next-state logic: fetch FSM, IF/ID load, skid buffer and PC/redirect update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    dinst_d     = dinst_q;
    dpc4_d      = dpc4_q;
    dvalid_d    = dvalid_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;
    pend_d      = pend_q;
    target_d    = target_q;

    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (ack_c && wpcir) begin
          dinst_d  = imem_rdata;
          dpc4_d   = pc_plus4_c;
          dvalid_d = 1'b1;
        end else if (ack_c) begin
          // ID stalled: park the word and stop fetching until it drains
          skid_inst_d = imem_rdata;
          skid_pc4_d  = pc_plus4_c;
          state_d     = S_FULL;
          req_d       = 1'b0;
        end else if (wpcir) begin
          dinst_d  = NOP_INST;
          dvalid_d = 1'b0;
        end
      end
      S_FULL: begin
        req_d = wpcir;
        if (wpcir) begin
          dinst_d  = skid_inst_q;
          dpc4_d   = skid_pc4_q;
          dvalid_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // PC moves only on an ack, except when the delay slot already sits in the skid
    if (ack_c) begin
      pend_d = 1'b0;
      if (pend_q) begin
        pc_d = target_q;
      end else if (redirect_c) begin
        pc_d = target_c & WORD_MASK;
      end else begin
        pc_d = pc_plus4_c;
      end
    end else if (redirect_c) begin
      if (req_q) begin
        target_d = target_c & WORD_MASK;
        pend_d   = 1'b1;
      end else begin
        pc_d = target_c & WORD_MASK;
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      dinst_q     <= NOP_INST;
      dpc4_q      <= '0;
      dvalid_q    <= 1'b0;
      skid_inst_q <= '0;
      skid_pc4_q  <= '0;
      pend_q      <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      dinst_q     <= dinst_d;
      dpc4_q      <= dpc4_d;
      dvalid_q    <= dvalid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
      pend_q      <= pend_d;
      target_q    <= target_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dinst     = dinst_q;
  assign dpc4      = dpc4_q;
  assign dvalid    = dvalid_q;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q;
  logic [XLEN-1:0] bubble_cnt_q;

  // Saturating counters: memory wait cycles and bubbles inserted into IF/ID
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (req_q && !imem_ack && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
      if (wpcir && (state_q == S_FETCH) && !ack_c && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
      end
    end
  end

  assign perf_stall_cyc  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Randomized bench for pipe_if_stage: a memory responder with configurable latency,
// an ID-stage stimulus generator, and a transaction-level model of the fetch stream.
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        wpcir = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, rpc = '0, jpc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dinst, dpc4;
  logic        dvalid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_bubble_cnt;
`endif

  pipe_if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clock(clock), .resetn(resetn), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dinst(dinst), .dpc4(dpc4), .dvalid(dvalid)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: the fetch stream as a FIFO of acked words plus the expected next fetch address
  logic [31:0] qa[$];
  logic [31:0] qi[$];
  logic [31:0] m_dinst, m_dpc4, m_next, last_acked, redir_after, redir_tgt;
  logic        m_dvalid, m_req, last_v, redir_pend;
  logic [31:0] lb;
  logic        lb_v;

  // Stimulus controls
  int          wcnt, lat, fix_lat, stall_n, stall_pct, br_pct;
  bit          rand_lat, force_en;
  logic [31:0] force_b, force_tgt;
  logic [1:0]  force_src;
  logic [31:0] seq[$];
  bit          rec_seq;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qi.delete();
    m_dinst = NOP_INST; m_dpc4 = '0; m_dvalid = 1'b0; m_req = 1'b0;
    m_next = RESET_PC; last_v = 1'b0; last_acked = '0;
    redir_pend = 1'b0; redir_after = '0; redir_tgt = '0; lb_v = 1'b0; lb = '0;
    wcnt = 0; lat = rand_lat ? 0 : fix_lat;
  endtask

  // One cycle: compare, drive inputs, clock edge, advance the model
  task automatic step();
    logic [31:0] tgt;
    chk("req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("addr", imem_addr, m_next);
    chk("dvalid", 32'(dvalid), 32'(m_dvalid));
    if (m_dvalid) begin
      chk("dinst", dinst, m_dinst);
      chk("dpc4", dpc4, m_dpc4);
    end else begin
      chk("bubble_inst", dinst, NOP_INST);
    end
    if (rec_seq && dvalid) seq.push_back(dpc4);

    imem_ack = 1'b0;
    imem_rdata = '0;
    if (m_req) begin
      if (wcnt >= lat) begin
        imem_ack = 1'b1;
        imem_rdata = mem(imem_addr);
        wcnt = 0;
        lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
      end else begin
        wcnt++;
      end
    end
    if (stall_n > 0) begin
      wpcir = 1'b0;
      stall_n--;
    end else begin
      wpcir = (int'($urandom_range(0, 99)) < stall_pct) ? 1'b0 : 1'b1;
    end
    bpc = $urandom() & 32'h0000_3FFC;
    rpc = $urandom() & 32'h0000_3FFC;
    jpc = $urandom() & 32'h0000_3FFC;
    pcsource = 2'b00;
    if (m_dvalid && wpcir && !(lb_v && (m_dpc4 - 32'd4 == lb + 32'd4))) begin
      if (force_en && (m_dpc4 - 32'd4 == force_b)) begin
        pcsource = force_src;
        bpc = force_tgt;
      end else if (int'($urandom_range(0, 99)) < br_pct) begin
        pcsource = 2'($urandom_range(1, 3));
      end
    end else if (!wpcir) begin
      pcsource = 2'($urandom_range(0, 3));
    end

    @(posedge clock);
    if (imem_ack) begin
      qa.push_back(m_next);
      qi.push_back(imem_rdata);
      last_acked = m_next;
      last_v = 1'b1;
      if (redir_pend && (m_next == redir_after)) begin
        m_next = redir_tgt;
        redir_pend = 1'b0;
      end else begin
        m_next = m_next + 32'd4;
      end
    end
    if (m_dvalid && wpcir && (pcsource != 2'b00)) begin
      tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? rpc : jpc;
      lb = m_dpc4 - 32'd4;
      lb_v = 1'b1;
      if (last_v && (last_acked == m_dpc4)) begin
        m_next = tgt;
      end else begin
        redir_after = m_dpc4;
        redir_tgt = tgt;
        redir_pend = 1'b1;
      end
    end
    if (wpcir) begin
      if (qa.size() != 0) begin
        m_dpc4 = qa.pop_front() + 32'd4;
        m_dinst = qi.pop_front();
        m_dvalid = 1'b1;
      end else begin
        m_dinst = NOP_INST;
        m_dvalid = 1'b0;
      end
    end
    m_req = (qa.size() == 0);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    imem_ack = 1'b0;
    wpcir = 1'b1;
    pcsource = 2'b00;
    model_reset();
    @(posedge clock);
    #3 resetn = 1'b1;
  endtask

  initial begin
    fix_lat = 0; rand_lat = 0; stall_n = 0; stall_pct = 0; br_pct = 0;
    force_en = 0; force_b = '0; force_tgt = '0; force_src = 2'b00; rec_seq = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_dinst", dinst, NOP_INST);
    chk("rst_dpc4", dpc4, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    #2 resetn = 1'b1;

    // Zero-wait stream with a taken branch at 0x10 whose delay-slot ack coincides
    force_en = 1; force_b = 32'h10; force_tgt = 32'h100; force_src = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 5) chk("zw_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2 && k <= 6) chk("zw_dpc4", dpc4, 32'(4 * (k - 1)));
      if (k == 7) begin
        chk("br_addr", imem_addr, 32'h100);
        chk("br_dslot", dpc4, 32'h18);
      end
      if (k == 8) begin
        chk("br_tgt_pc4", dpc4, 32'h104);
        chk("br_tgt_inst", dinst, mem(32'h100));
      end
    end

    // 3-cycle memory with the delay-slot fetch still outstanding at the branch
    fix_lat = 2;
    do_reset();
    rec_seq = 1;
    repeat (30) step();
    rec_seq = 0;
    if (seq.size() >= 7) begin
      chk("pend_br", seq[4], 32'h14);
      chk("pend_dslot", seq[5], 32'h18);
      chk("pend_tgt", seq[6], 32'h104);
    end else begin
      chk("pend_seq_len", 32'(seq.size()), 32'd7);
    end
    force_en = 0;

    // ID stall for 4 cycles while acks keep arriving
    fix_lat = 0;
    do_reset();
    repeat (5) step();
    stall_n = 4;
    repeat (10) step();

    // Random latency, stalls and redirects
    rand_lat = 1; stall_pct = 25; br_pct = 20;
    do_reset();
    repeat (3000) step();

    // Asynchronous reset with the skid holding a word
    rand_lat = 0; fix_lat = 0; stall_pct = 0; br_pct = 0;
    stall_n = 1000;
    for (int k = 0; k < 10 && qa.size() == 0; k++) step();
    chk("skid_full", 32'(imem_req), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_dvalid", 32'(dvalid), 32'd0);
    chk("arst_dinst", dinst, NOP_INST);
    chk("arst_dpc4", dpc4, 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    stall_n = 0;
    wpcir = 1'b1;
    imem_ack = 1'b0;
    model_reset();
    @(posedge clock);
    #3 resetn = 1'b1;
    step();
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
